// File: rtl/pps_detect.sv
// PPS input conditioner: synchronizes pps_in, emits one tick per rising edge,
// qualifies the edge-to-edge interval and tracks lock. Optional error
// statistics are built only when PPS_DETECT_STATS_EN is defined.
module pps_detect #(
  parameter  int CLK_FREQ    = 50_000_000,
  parameter  int TOL         = 1000,
  parameter  int SYNC_STAGES = 2,
  parameter  int LOCK_COUNT  = 4,
  localparam int W           = $clog2(CLK_FREQ + TOL + 2)
) (
  input  logic         rst_n,
  input  logic         clk,
  input  logic         pps_in,
  output logic         pps_pulse,
  output logic         pps_valid,
  output logic         pps_missing,
  output logic [W-1:0] period,
  output logic [7:0]   err_count
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [W-1:0] CNT_MAX = W'(CLK_FREQ + TOL + 1);
  localparam logic [W-1:0] CNT_HI  = W'(CLK_FREQ + TOL);
  localparam logic [W-1:0] CNT_LO  = W'(CLK_FREQ - TOL);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          good_q, good_d;
  logic [W-1:0]           period_d;
  logic [W-1:0]           cnt_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   pps_edge;
  logic                   interval_good;
  logic                   timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pps_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pps_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Saturating count means cnt never wraps back into the good window while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (pps_edge) begin
      cnt_q <= W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign interval_good = (cnt_q >= CNT_LO) && (cnt_q <= CNT_HI);
  assign timeout       = !pps_edge && (cnt_q == CNT_HI) && (state_q != SEARCH);

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    period_d = period;
    case (state_q)
      SEARCH: begin
        if (pps_edge) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (pps_edge) begin
          period_d = cnt_q;
          if (interval_good) begin
            good_d = good_q + GW'(1);
            if (good_q + GW'(1) == GW'(LOCK_COUNT)) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end else if (timeout) begin
          state_d = SEARCH;
        end
      end
      LOCKED: begin
        if (pps_edge) begin
          period_d = cnt_q;
          if (!interval_good) begin
            state_d = ACQUIRE;
            good_d  = '0;
          end
        end else if (timeout) begin
          state_d = SEARCH;
        end
      end
      default: begin
        state_d = SEARCH;
        good_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      good_q      <= '0;
      period      <= '0;
      pps_pulse   <= 1'b0;
      pps_valid   <= 1'b0;
      pps_missing <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      period      <= period_d;
      pps_pulse   <= pps_edge;
      pps_valid   <= (state_d == LOCKED);
      pps_missing <= timeout;
    end
  end

`ifdef PPS_DETECT_STATS_EN
  logic bad_evt;
  assign bad_evt = (pps_edge && (state_q != SEARCH) && !interval_good) || timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (bad_evt && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_count = 8'd0;
`endif

endmodule
